// File: rtl/cnn_pkg.sv
// Shared widths, state type and readout FSM encoding for the
// 4x4 CNN tile readout path.
package cnn_pkg;

   localparam int WIDTH = 9;
   localparam int YW    = 2*WIDTH-1;
   localparam int CELLS = 16;

   typedef logic signed [YW-1:0] ystate_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/cnn_sweep_tracker.sv
// Follows the tile's 16-cycle cell sweep and flags the cycle in which
// the settled frame is visible on the tile outputs.
module cnn_sweep_tracker
   import cnn_pkg::*;
#(
   parameter int ITERATIONS = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic run,
   output logic capture_now
);

   localparam logic [7:0] ITER8 = 8'(ITERATIONS);

   logic [3:0] phase_q, phase_d;
   logic [7:0] sweeps_q, sweeps_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q  <= '0;
         sweeps_q <= '0;
      end else begin
         phase_q  <= phase_d;
         sweeps_q <= sweeps_d;
      end
   end

   // phase_q mirrors the tile counter of the current cycle; the start
   // cycle is phase 0, so a restart loads phase 1 for the next cycle.
   always_comb begin
      phase_d  = phase_q;
      sweeps_d = sweeps_q;
      if (restart) begin
         phase_d  = 4'd1;
         sweeps_d = '0;
      end else if (run) begin
         phase_d = phase_q + 4'd1;
         if (phase_q == 4'd15) begin
            sweeps_d = sweeps_q + 8'd1;
         end
      end else begin
         phase_d  = '0;
         sweeps_d = '0;
      end
   end

   assign capture_now = run && (sweeps_q == ITER8) && (phase_q == 4'd1);

endmodule

// File: rtl/cnn_tile_readout.sv
// Reader end of the 4x4 CNN tile: waits a number of sweeps, snapshots
// the 16 Y outputs and streams them one cell per valid/ready beat.
module cnn_tile_readout
   import cnn_pkg::*;
#(
   parameter int ITERATIONS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  ystate_t    y_in [CELLS],
   output ystate_t    m_data,
   output logic       m_pixel,
   output logic [3:0] m_index,
   output logic       m_last,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       busy,
   output logic       overrun
);

   rd_state_t  state_q, state_d;
   ystate_t    snap_q [CELLS];
   ystate_t    snap_d [CELLS];
   logic [3:0] beat_q, beat_d;
   logic       overrun_q, overrun_d;

   logic hs, final_hs, restart, capture_now, do_capture;

   assign hs         = (state_q == DRAIN) && m_ready;
   assign final_hs   = hs && (beat_q == 4'd15);
   // A start landing on the final handshake counts as a fresh start.
   assign restart    = start && ((state_q != DRAIN) || final_hs);
   assign do_capture = (state_q == RUN) && !start && capture_now;

   cnn_sweep_tracker #(
      .ITERATIONS(ITERATIONS)
   ) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .restart    (restart),
      .run        (state_q == RUN),
      .capture_now(capture_now)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         snap_q    <= '{default: '0};
         beat_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         beat_q    <= beat_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (do_capture) state_d = DRAIN;
         DRAIN:   if (final_hs) state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      snap_d    = snap_q;
      beat_d    = beat_q;
      overrun_d = overrun_q;
      if (do_capture) begin
         snap_d = y_in;
      end
      if (hs) begin
         beat_d = final_hs ? 4'd0 : beat_q + 4'd1;
      end
      if (start && (state_q == DRAIN) && !final_hs) begin
         overrun_d = 1'b1;
      end
   end

   always_comb begin
      m_valid = (state_q == DRAIN);
      m_data  = m_valid ? snap_q[beat_q] : '0;
      m_pixel = m_valid && !m_data[YW-1];
      m_index = m_valid ? beat_q : 4'd0;
      m_last  = m_valid && (beat_q == 4'd15);
      busy    = (state_q == RUN) || (state_q == DRAIN);
      overrun = overrun_q;
   end

endmodule

// File: tb/tb_cnn_tile_readout.sv
// Self-checking bench for cnn_tile_readout: table-driven first frame,
// randomized frames against a frame/queue model, and corner sequences.
module tb_cnn_tile_readout;
   import cnn_pkg::*;

   logic       clk = 1'b0;
   logic       rst, start, m_ready;
   ystate_t    y_in [CELLS];

   ystate_t    d1, d2;
   logic       p1, p2, l1, l2, v1, v2, b1, b2, o1, o2;
   logic [3:0] i1, i2;

   cnn_tile_readout #(.ITERATIONS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .y_in(y_in),
      .m_data(d1), .m_pixel(p1), .m_index(i1), .m_last(l1),
      .m_valid(v1), .m_ready(m_ready), .busy(b1), .overrun(o1)
   );

   cnn_tile_readout #(.ITERATIONS(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .y_in(y_in),
      .m_data(d2), .m_pixel(p2), .m_index(i2), .m_last(l2),
      .m_valid(v2), .m_ready(m_ready), .busy(b2), .overrun(o2)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit sel2 = 1'b0;

   ystate_t    cd;
   logic       cp, cl, cv, cb, co;
   logic [3:0] ci;

   always_comb begin
      cd = sel2 ? d2 : d1;
      cp = sel2 ? p2 : p1;
      cl = sel2 ? l2 : l1;
      cv = sel2 ? v2 : v1;
      cb = sel2 ? b2 : b1;
      co = sel2 ? o2 : o1;
      ci = sel2 ? i2 : i1;
   end

   typedef struct {
      int idx;
      int data;
      bit pixel;
      bit last;
   } vec_t;

   vec_t    tbl [CELLS];
   ystate_t fr  [CELLS];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic rand_frame();
      foreach (y_in[k]) y_in[k] = ystate_t'($urandom);
      fr = y_in;
   endtask

   // Called just after the start edge: expects silence for 16*iter
   // edges and the first beat right after edge 16*iter+1.
   task automatic wait_capture(input int iter);
      bit early = 1'b0;
      for (int e = 1; e <= 16*iter; e++) begin
         @(posedge clk); #1;
         if (cv) early = 1'b1;
      end
      chk("no_early_beat", early, 0);
      @(posedge clk); #1;
      chk("capture_edge_valid", cv, 1);
   endtask

   // Reference stream: beats must be fr[0..15] in order, each exactly
   // once, holding while the sink stalls.
   task automatic drain(input ystate_t f [CELLS], input int rmode,
                        input bit iso, input int start_at,
                        input int rst_at);
      int   idx    = 0;
      int   cyc    = 0;
      bit   pulsed = 1'b0;
      logic r;
      if (iso) foreach (y_in[k]) y_in[k] = 17'h0FFFF;
      while (idx < CELLS && cyc < 400) begin
         chk("beat_valid", cv, 1);
         if (cv) begin
            chk("beat_index", ci, idx);
            chk("beat_data", cd, f[idx]);
            chk("beat_pixel", cp, f[idx] >= 0);
            chk("beat_last", cl, idx == CELLS-1);
         end
         if (idx == rst_at) begin
            m_ready = 1'b0;
            pulse_rst();
            chk("rst_valid", cv, 0);
            chk("rst_busy", cb, 0);
            chk("rst_overrun", co, 0);
            chk("rst_last", cl, 0);
            return;
         end
         case (rmode)
            0:       r = 1'b1;
            1:       r = (cyc % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (idx == start_at && !pulsed) begin
            start  = 1'b1;
            pulsed = 1'b1;
            if (idx == CELLS-1) r = 1'b1;
         end
         m_ready = r;
         if (cv && r) idx++;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      m_ready = 1'b0;
      chk("frame_beats", idx, CELLS);
      chk("valid_after_last", cv, 0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      m_ready = 1'b0;
      foreach (y_in[k]) y_in[k] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", cv, 0);
      chk("reset_busy", cb, 0);
      chk("reset_overrun", co, 0);
      chk("reset_data", cd, 0);
      chk("reset_index", ci, 0);
      chk("reset_last", cl, 0);
      chk("reset_pixel", cp, 0);
      rst = 1'b0;

      for (int k = 0; k < CELLS; k++) begin
         tbl[k]  = '{idx: k, data: k-8, pixel: (k >= 8), last: (k == 15)};
         y_in[k] = ystate_t'(k-8);
      end
      pulse_start();
      wait_capture(1);
      m_ready = 1'b1;
      for (int k = 0; k < CELLS; k++) begin
         chk("tbl_valid", cv, 1);
         chk("tbl_index", ci, tbl[k].idx);
         chk("tbl_data", cd, tbl[k].data);
         chk("tbl_pixel", cp, tbl[k].pixel);
         chk("tbl_last", cl, tbl[k].last);
         @(posedge clk); #1;
      end
      m_ready = 1'b0;
      chk("tbl_valid_drop", cv, 0);
      chk("tbl_busy_drop", cb, 0);

      // backpressure 1,0,0 with inputs changed after capture
      rand_frame();
      pulse_start();
      wait_capture(1);
      drain(fr, 1, 1'b1, -1, -1);

      for (int n = 0; n < 3; n++) begin
         rand_frame();
         pulse_start();
         wait_capture(1);
         drain(fr, 2, 1'($urandom_range(0, 1)), -1, -1);
      end

      // restart mid-run on the ITERATIONS=2 instance
      sel2 = 1'b1;
      pulse_rst();
      rand_frame();
      pulse_start();
      begin
         bit early = 1'b0;
         for (int e = 1; e <= 52; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cv) early = 1'b1;
            if (e == 19) start = 1'b1;
         end
         chk("restart_no_early", early, 0);
      end
      @(posedge clk); #1;
      chk("restart_capture_valid", cv, 1);
      drain(fr, 0, 1'b0, -1, -1);
      sel2 = 1'b0;

      // start during drain sets a sticky overrun
      pulse_rst();
      rand_frame();
      pulse_start();
      wait_capture(1);
      chk("overrun_before", co, 0);
      drain(fr, 0, 1'b0, 5, -1);
      chk("overrun_set", co, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("overrun_sticky", co, 1);
      chk("overrun_idle", cb, 0);

      // rst in the middle of a stream
      rand_frame();
      pulse_start();
      wait_capture(1);
      drain(fr, 0, 1'b0, -1, 9);
      rand_frame();
      pulse_start();
      wait_capture(1);
      drain(fr, 2, 1'b0, -1, -1);

      // start on the final handshake re-enters RUN
      rand_frame();
      pulse_start();
      wait_capture(1);
      drain(fr, 0, 1'b0, 15, -1);
      chk("last_start_busy", cb, 1);
      chk("last_start_overrun", co, 0);
      wait_capture(1);
      drain(fr, 0, 1'b0, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
